// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU select encoding, default
// datapath widths and the bit positions inside the forwarded control bundles.
package alu_pkg;

  // Default widths for the datapath and the register-file address.
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_REG_AW = 5;

  // ALU select encoding as produced by the ALU control unit.
  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

  // Widths of the control bundles forwarded to MEM and WB.
  localparam int CTRL_WB_W  = 2;
  localparam int CTRL_MEM_W = 3;

  // Bit positions inside ctrl_wb = {RegWrite, MemtoReg}.
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // Bit positions inside ctrl_mem = {Branch, MemRead, MemWrite}.
  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: AND, OR, ADD, SUB, SLT. Any other select value yields a
// zero result and raises the illegal flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  logic a_lt_b;

  // Signed compare; correct across overflow because no subtraction is involved.
  always_comb begin
    a_lt_b = ($signed(a) < $signed(b));
  end

  // Operation decode; an unmatched select (including X/Z bits) falls to default.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    result  = '0;
    illegal = 1'b0;
    case (select)
      SEL_AND: result = a & b;
      SEL_OR:  result = a | b;
      SEL_ADD: result = a + b;
      SEL_SUB: result = a - b;
      SEL_SLT: result = {{(WIDTH-1){1'b0}}, a_lt_b};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// MIPS execute stage: operand-B mux, ALU, destination mux, branch adder and
// the EX/MEM pipeline register with flush/stall control from the hazard unit.
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [2:0]            select,
  input  logic [WIDTH-1:0]      rd_data1,
  input  logic [WIDTH-1:0]      rd_data2,
  input  logic [WIDTH-1:0]      imm_ext,
  input  logic                  alu_src,
  input  logic                  reg_dst,
  input  logic [REG_AW-1:0]     rt,
  input  logic [REG_AW-1:0]     rd,
  input  logic [WIDTH-1:0]      pc_plus4,
  input  logic [CTRL_WB_W-1:0]  ctrl_wb,
  input  logic [CTRL_MEM_W-1:0] ctrl_mem,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      alu_result,
  output logic                  zero,
  output logic [WIDTH-1:0]      branch_target,
  output logic [WIDTH-1:0]      store_data,
  output logic [REG_AW-1:0]     write_reg,
  output logic [CTRL_WB_W-1:0]  ctrl_wb_q,
  output logic [CTRL_MEM_W-1:0] ctrl_mem_q,
  output logic                  illegal_sel
);

  logic [WIDTH-1:0]      alu_b;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_ill;
  logic                  res_zero;
  logic [REG_AW-1:0]     dest;
  logic [WIDTH-1:0]      target;
  logic [CTRL_WB_W-1:0]  wb_gated;
  logic [CTRL_MEM_W-1:0] mem_gated;

  // Operand B comes from the register file or the sign-extended immediate.
  always_comb begin
    alu_b = alu_src ? imm_ext : rd_data2;
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a       (rd_data1),
    .b       (alu_b),
    .select  (select),
    .result  (alu_res),
    .illegal (alu_ill)
  );

  // Zero flag on the final result, whatever operation produced it.
  always_comb begin
    res_zero = (alu_res == '0);
  end

  // Destination register: rt for I-type, rd for R-type.
  always_comb begin
    dest = reg_dst ? rd : rt;
  end

  // Branch target: word offset shifted into a byte offset, wrapping add.
  always_comb begin
    target = pc_plus4 + {imm_ext[WIDTH-3:0], 2'b00};
  end

  // A bubble in the ID/EX slot must never enable a write further down.
  always_comb begin
    wb_gated                 = '0;
    mem_gated                = '0;
    wb_gated[WB_REG_WRITE]   = in_valid & ctrl_wb[WB_REG_WRITE];
    wb_gated[WB_MEM_TO_REG]  = in_valid & ctrl_wb[WB_MEM_TO_REG];
    mem_gated[MEM_BRANCH]    = in_valid & ctrl_mem[MEM_BRANCH];
    mem_gated[MEM_READ]      = in_valid & ctrl_mem[MEM_READ];
    mem_gated[MEM_WRITE]     = in_valid & ctrl_mem[MEM_WRITE];
  end

  // EX/MEM register: flush beats stall, stall beats capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      out_valid     <= 1'b0;
      alu_result    <= '0;
      zero          <= 1'b0;
      branch_target <= '0;
      store_data    <= '0;
      write_reg     <= '0;
      ctrl_wb_q     <= '0;
      ctrl_mem_q    <= '0;
      illegal_sel   <= 1'b0;
    end else if (flush) begin
      // Bubble: everything cleared except the sticky illegal flag.
      out_valid     <= 1'b0;
      alu_result    <= '0;
      zero          <= 1'b0;
      branch_target <= '0;
      store_data    <= '0;
      write_reg     <= '0;
      ctrl_wb_q     <= '0;
      ctrl_mem_q    <= '0;
    end else if (!stall) begin
      out_valid     <= in_valid;
      alu_result    <= alu_res;
      zero          <= res_zero;
      branch_target <= target;
      store_data    <= rd_data2;
      write_reg     <= dest;
      ctrl_wb_q     <= wb_gated;
      ctrl_mem_q    <= mem_gated;
      if (in_valid && alu_ill) begin
        illegal_sel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the EX/MEM register.
module tb_ex_alu_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [2:0]  select;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic [31:0] imm_ext;
  logic        alu_src;
  logic        reg_dst;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] pc_plus4;
  logic [1:0]  ctrl_wb;
  logic [2:0]  ctrl_mem;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] branch_target;
  logic [31:0] store_data;
  logic [4:0]  write_reg;
  logic [1:0]  ctrl_wb_q;
  logic [2:0]  ctrl_mem_q;
  logic        illegal_sel;

  int checks = 0;
  int errors = 0;

  // Model of what the EX/MEM register should hold.
  logic        e_valid;
  logic [31:0] e_res;
  logic        e_zero;
  logic [31:0] e_bt;
  logic [31:0] e_sd;
  logic [4:0]  e_wr;
  logic [1:0]  e_wb;
  logic [2:0]  e_mem;
  logic        e_ill;

  ex_alu_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .select(select), .rd_data1(rd_data1),
    .rd_data2(rd_data2), .imm_ext(imm_ext), .alu_src(alu_src),
    .reg_dst(reg_dst), .rt(rt), .rd(rd), .pc_plus4(pc_plus4),
    .ctrl_wb(ctrl_wb), .ctrl_mem(ctrl_mem), .out_valid(out_valid),
    .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
    .store_data(store_data), .write_reg(write_reg), .ctrl_wb_q(ctrl_wb_q),
    .ctrl_mem_q(ctrl_mem_q), .illegal_sel(illegal_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU from the operation table: returns {illegal, result}.
  function automatic logic [32:0] ref_alu(input logic [2:0] s, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s == 3'd0)      return {1'b0, a & b};
    else if (s == 3'd1) return {1'b0, a | b};
    else if (s == 3'd2) return {1'b0, 32'(a + b)};
    else if (s == 3'd6) return {1'b0, 32'(a - b)};
    else if (s == 3'd7) return {1'b0, (sa < sb) ? 32'd1 : 32'd0};
    else                return {1'b1, 32'd0};
  endfunction

  task automatic model_clear();
    e_valid = 0; e_res = 0; e_zero = 0; e_bt = 0; e_sd = 0;
    e_wr = 0; e_wb = 0; e_mem = 0; e_ill = 0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    logic [32:0] r;
    logic [31:0] b;
    b = alu_src ? imm_ext : rd_data2;
    r = ref_alu(select, rd_data1, b);
    if (flush) begin
      e_valid = 0; e_res = 0; e_zero = 0; e_bt = 0; e_sd = 0;
      e_wr = 0; e_wb = 0; e_mem = 0;
    end else if (!stall) begin
      e_valid = in_valid;
      e_res   = r[31:0];
      e_zero  = (r[31:0] == 32'd0);
      e_bt    = pc_plus4 + imm_ext * 32'd4;
      e_sd    = rd_data2;
      e_wr    = reg_dst ? rd : rt;
      e_wb    = in_valid ? ctrl_wb : 2'b00;
      e_mem   = in_valid ? ctrl_mem : 3'b000;
      if (in_valid && r[32]) e_ill = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1; select = s; rd_data1 = a; rd_data2 = b; alu_src = 0;
    stall = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; flush = 0; in_valid = 0; select = 0;
    rd_data1 = 0; rd_data2 = 0; imm_ext = 0; alu_src = 0; reg_dst = 0;
    rt = 0; rd = 0; pc_plus4 = 0; ctrl_wb = 0; ctrl_mem = 0;
    model_clear();
    repeat (2) @(negedge clk);
    checks++; if ({out_valid, alu_result, zero, branch_target, store_data, write_reg,
                   ctrl_wb_q, ctrl_mem_q, illegal_sel} !== '0) begin
      errors++; $display("FAIL reset_state got valid=%b res=%h bt=%h ill=%b want all 0",
                         out_valid, alu_result, branch_target, illegal_sel);
    end
    rst_n = 1;
  endtask

  task automatic test_arith();
    rt = 5'd3; rd = 5'd9; reg_dst = 1; ctrl_wb = 2'b10; ctrl_mem = 3'b000;
    pc_plus4 = 32'h40; imm_ext = 32'd0;
    set_op(SEL_ADD, 32'd7, 32'd5); tick();
    checks++; if (alu_result !== 32'd12 || zero !== 1'b0) begin
      errors++; $display("FAIL add_7_5 got %h z=%b want 0000000c z=0", alu_result, zero);
    end
    checks++; if (out_valid !== 1'b1 || write_reg !== 5'd9 || ctrl_wb_q !== 2'b10) begin
      errors++; $display("FAIL add_ctrl got v=%b wr=%0d wb=%b want v=1 wr=9 wb=10",
                         out_valid, write_reg, ctrl_wb_q);
    end
    set_op(SEL_SUB, 32'd5, 32'd5); tick();
    checks++; if (alu_result !== 32'd0 || zero !== 1'b1) begin
      errors++; $display("FAIL sub_equal got %h z=%b want 0 z=1", alu_result, zero);
    end
    set_op(SEL_SLT, 32'hFFFF_FFFF, 32'd1); tick();
    checks++; if (alu_result !== 32'd1 || zero !== 1'b0) begin
      errors++; $display("FAIL slt_neg1_1 got %h z=%b want 1 z=0", alu_result, zero);
    end
    set_op(SEL_SLT, 32'h8000_0000, 32'd1); tick();
    checks++; if (alu_result !== 32'd1) begin
      errors++; $display("FAIL slt_overflow got %h want 1", alu_result);
    end
    set_op(SEL_SLT, 32'd1, 32'h8000_0000); tick();
    checks++; if (alu_result !== 32'd0 || zero !== 1'b1) begin
      errors++; $display("FAIL slt_false got %h z=%b want 0 z=1", alu_result, zero);
    end
    set_op(SEL_ADD, 32'hFFFF_FFFF, 32'd2); tick();
    checks++; if (alu_result !== 32'd1) begin
      errors++; $display("FAIL add_wrap got %h want 1", alu_result);
    end
  endtask

  task automatic test_imm_branch();
    set_op(SEL_ADD, 32'h10, 32'h1234_5678);
    alu_src = 1; imm_ext = 32'hFFFF_FFFC; pc_plus4 = 32'h100;
    reg_dst = 0; rt = 5'd3; rd = 5'd9; ctrl_mem = 3'b100;
    tick();
    checks++; if (alu_result !== 32'h0C) begin
      errors++; $display("FAIL imm_add got %h want 0000000c", alu_result);
    end
    checks++; if (branch_target !== 32'hF0) begin
      errors++; $display("FAIL branch_target got %h want 000000f0", branch_target);
    end
    checks++; if (write_reg !== 5'd3 || store_data !== 32'h1234_5678) begin
      errors++; $display("FAIL rt_dest got wr=%0d sd=%h want wr=3 sd=12345678",
                         write_reg, store_data);
    end
    checks++; if (ctrl_mem_q[MEM_BRANCH] !== 1'b1) begin
      errors++; $display("FAIL branch_ctrl got %b want 1xx", ctrl_mem_q);
    end
  endtask

  task automatic test_stall_flush();
    set_op(SEL_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    reg_dst = 1; rt = 5'd4; rd = 5'd7; pc_plus4 = 32'h200; imm_ext = 32'd5;
    ctrl_wb = 2'b10; ctrl_mem = 3'b001;
    tick();
    checks++; if (alu_result !== 32'h00F0_1200) begin
      errors++; $display("FAIL and_capture got %h want 00f01200", alu_result);
    end
    for (int i = 0; i < 3; i++) begin
      stall = 1;
      select = 3'(i + 1); rd_data1 = $urandom; rd_data2 = $urandom; rd = 5'(i);
      pc_plus4 = $urandom; ctrl_wb = 2'b01; in_valid = i[0];
      tick();
      checks++; if (alu_result !== 32'h00F0_1200 || write_reg !== 5'd7 ||
                    branch_target !== 32'h214 || store_data !== 32'h0FF0_FF00 ||
                    out_valid !== 1'b1 || ctrl_wb_q !== 2'b10 || ctrl_mem_q !== 3'b001) begin
        errors++; $display("FAIL stall_hold[%0d] got res=%h wr=%0d bt=%h sd=%h v=%b wb=%b mem=%b",
                           i, alu_result, write_reg, branch_target, store_data,
                           out_valid, ctrl_wb_q, ctrl_mem_q);
      end
    end
    stall = 1; flush = 1; in_valid = 1;
    tick();
    checks++; if (out_valid !== 1'b0 || ctrl_wb_q !== 2'b00 || ctrl_mem_q !== 3'b000 ||
                  alu_result !== 32'd0 || branch_target !== 32'd0 || write_reg !== 5'd0) begin
      errors++; $display("FAIL stall_flush got v=%b wb=%b mem=%b res=%h bt=%h want all 0",
                         out_valid, ctrl_wb_q, ctrl_mem_q, alu_result, branch_target);
    end
    set_op(SEL_OR, 32'd1, 32'd2); rd = 5'd11; ctrl_wb = 2'b11;
    tick();
    checks++; if (alu_result !== 32'd3 || write_reg !== 5'd11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL post_stall_capture got res=%h wr=%0d v=%b want 3 11 1",
                         alu_result, write_reg, out_valid);
    end
  endtask

  task automatic test_bubble();
    set_op(SEL_ADD, 32'd20, 32'd22); in_valid = 0; ctrl_wb = 2'b11; ctrl_mem = 3'b111;
    tick();
    checks++; if (out_valid !== 1'b0 || ctrl_wb_q !== 2'b00 || ctrl_mem_q !== 3'b000) begin
      errors++; $display("FAIL bubble_ctrl got v=%b wb=%b mem=%b want 0 00 000",
                         out_valid, ctrl_wb_q, ctrl_mem_q);
    end
    checks++; if (alu_result !== 32'd42) begin
      errors++; $display("FAIL bubble_data got %h want 0000002a", alu_result);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    set_op(3'b101, 32'd5, 32'd3); tick();
    checks++; if (alu_result !== 32'd0 || zero !== 1'b1 || illegal_sel !== 1'b1) begin
      errors++; $display("FAIL illegal_101 got res=%h z=%b ill=%b want 0 1 1",
                         alu_result, zero, illegal_sel);
    end
    for (int i = 0; i < 5; i++) begin
      set_op(SEL_ADD, 32'(i), 32'd100); tick();
      checks++; if (illegal_sel !== 1'b1 || alu_result !== 32'(100 + i)) begin
        errors++; $display("FAIL illegal_sticky[%0d] got ill=%b res=%h want 1 %h",
                           i, illegal_sel, alu_result, 32'(100 + i));
      end
    end
    flush = 1; tick();
    checks++; if (illegal_sel !== 1'b1) begin
      errors++; $display("FAIL illegal_after_flush got %b want 1", illegal_sel);
    end
    do_reset();
    set_op(3'b100, 32'd5, 32'd3); in_valid = 0; tick();
    checks++; if (illegal_sel !== 1'b0 || alu_result !== 32'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_bubble got ill=%b res=%h v=%b want 0 0 0",
                         illegal_sel, alu_result, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    set_op(3'b011, 32'd1, 32'd1); tick();
    set_op(SEL_OR, 32'hA5A5_0000, 32'h0000_5A5A); ctrl_wb = 2'b11; ctrl_mem = 3'b010;
    pc_plus4 = 32'h1000; imm_ext = 32'd8; tick();
    stall = 1; flush = 1;
    #2 rst_n = 0;
    model_clear();
    #1;
    checks++; if ({out_valid, alu_result, zero, branch_target, store_data, write_reg,
                   ctrl_wb_q, ctrl_mem_q, illegal_sel} !== '0) begin
      errors++; $display("FAIL async_reset got v=%b res=%h bt=%h sd=%h ill=%b want all 0",
                         out_valid, alu_result, branch_target, store_data, illegal_sel);
    end
    @(negedge clk);
    rst_n = 1; stall = 0; flush = 0;
  endtask

  task automatic test_random();
    logic [2:0] sels [8];
    sels = '{SEL_AND, SEL_OR, SEL_ADD, SEL_SUB, SEL_SLT, 3'b011, 3'b100, 3'b101};
    do_reset();
    for (int i = 0; i < 300; i++) begin
      select   = (i < 150) ? sels[$urandom_range(0, 4)] : sels[$urandom_range(0, 7)];
      rd_data1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rd_data2 = ($urandom_range(0, 3) == 0) ? rd_data1 : $urandom;
      imm_ext  = $urandom; pc_plus4 = $urandom;
      alu_src  = 1'($urandom); reg_dst = 1'($urandom);
      rt = 5'($urandom); rd = 5'($urandom);
      ctrl_wb = 2'($urandom); ctrl_mem = 3'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      tick();
      checks++; if (out_valid !== e_valid || alu_result !== e_res || zero !== e_zero ||
                    branch_target !== e_bt || store_data !== e_sd || write_reg !== e_wr ||
                    ctrl_wb_q !== e_wb || ctrl_mem_q !== e_mem || illegal_sel !== e_ill) begin
        errors++;
        $display("FAIL random[%0d] got v=%b res=%h z=%b bt=%h sd=%h wr=%0d wb=%b mem=%b ill=%b want v=%b res=%h z=%b bt=%h sd=%h wr=%0d wb=%b mem=%b ill=%b",
                 i, out_valid, alu_result, zero, branch_target, store_data, write_reg,
                 ctrl_wb_q, ctrl_mem_q, illegal_sel, e_valid, e_res, e_zero, e_bt,
                 e_sd, e_wr, e_wb, e_mem, e_ill);
      end
    end
    stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_imm_branch();
    test_stall_flush();
    test_bubble();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute-stage datapath and EX/MEM pipeline register for the MIPS pipeline. Consumes the 3-bit ALU select produced by the ALU control unit, together with the ID/EX operands and control bits. Computes the ALU result, zero flag, branch target and destination register, and latches them with the forwarded MEM/WB control into the EX/MEM register for the memory stage. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
- WIDTH, 32, datapath width in bits
- REG_AW, 5, register-file address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold EX/MEM register contents
- flush  in  1  load a bubble into EX/MEM
- in_valid  in  1  ID/EX slot holds a real instruction
- select  in  3  ALU operation from ALU control, aligned with the operands this cycle
- rd_data1  in  WIDTH  operand A (rs)
- rd_data2  in  WIDTH  rs-independent operand (rt); also the store data
- imm_ext  in  WIDTH  sign-extended immediate
- alu_src  in  1  0: B = rd_data2, 1: B = imm_ext
- reg_dst  in  1  0: dest = rt, 1: dest = rd
- rt, rd  in  REG_AW each  candidate destination fields
- pc_plus4  in  WIDTH  PC+4 of this instruction
- ctrl_wb  in  2  {RegWrite, MemtoReg}
- ctrl_mem  in  3  {Branch, MemRead, MemWrite}
- out_valid  out  1  EX/MEM slot valid
- alu_result  out  WIDTH  registered ALU result
- zero  out  1  registered (alu_result == 0)
- branch_target  out  WIDTH  registered pc_plus4 + (imm_ext << 2)
- store_data  out  WIDTH  registered rd_data2
- write_reg  out  REG_AW  registered destination
- ctrl_wb_q  out  2  registered ctrl_wb
- ctrl_mem_q  out  3  registered ctrl_mem
- illegal_sel  out  1  sticky: an unsupported select was captured

## Operation
- Select encoding: 000 AND; 001 OR; 010 ADD; 110 SUB (A−B); 111 SLT (signed A<B → 1, else 0, zero-extended).
- Any other select value (011, 100, 101, or any X/Z bit): the result is 0, and the operation is flagged as illegal.
- ADD and SUB wrap modulo 2^WIDTH; there is no overflow trap or flag.
- SLT uses signed compare, and is correct across overflow (e.g. 0x80000000 < 0x00000001 → 1).
- The zero flag is computed on the final result, including SLT and illegal-select results.
- branch_target shifts the immediate left by 2, discards the top 2 bits and wraps modulo 2^WIDTH.
- The EX/MEM register has three update modes, in priority order:
  - flush=1: out_valid, ctrl_wb_q and ctrl_mem_q are set to 0; data fields are set to 0.
  - else stall=1: all outputs hold, including illegal_sel.
  - else: capture the computed values; out_valid = in_valid.
- When in_valid=0 and the register captures, ctrl_wb_q and ctrl_mem_q are forced to 0, so no stray write occurs. Data fields are still captured.
- illegal_sel sets on a capture cycle with in_valid=1 and an illegal select. It is cleared only by reset.

## Timing
- Latency: exactly 1 cycle from inputs to registered outputs.
- Throughput: 1 instruction per cycle when stall=0.
- Reset (asynchronous assert, synchronous release) sets every output to 0: out_valid, alu_result, zero, branch_target, store_data, write_reg, ctrl_wb_q, ctrl_mem_q, illegal_sel.
- Reset asserted mid-stall or mid-flush overrides both immediately.
- When flush and stall are asserted in the same cycle, flush wins.
- Held outputs under a multi-cycle stall stay bit-identical for every stalled cycle.
- The first capture after a stall releases uses the inputs present on that edge; no input is buffered during a stall.

## Structure
- A shared package `alu_pkg` holds:
  - the select encoding constants SEL_AND, SEL_OR, SEL_ADD, SEL_SUB, SEL_SLT;
  - the WIDTH and REG_AW defaults;
  - the ctrl_wb and ctrl_mem bit-position constants.
- The combinational ALU is one sub-module, `alu_core`.
  - Inputs: a, b, select. Outputs: result, illegal.
- The top level holds:
  - the B mux, the destination mux and the branch adder;
  - the EX/MEM register, which carries the stall/flush priority.

## Test plan
- Reset then idle: rst_n low mid-run → all outputs 0 asynchronously, before the next clock edge.
- Arithmetic: A=7, B=5 (alu_src=0), select 010 → 12 and zero=0. Select 110 with A=B=5 → 0 and zero=1. Select 111, A=0xFFFFFFFF, B=1 → 1.
- Immediate and branch: alu_src=1, imm_ext=0xFFFFFFFC, pc_plus4=0x100, select 010 with A=0x10 → alu_result 0x0C, branch_target 0xF0. Also check reg_dst=0 gives write_reg=rt.
- Stall/flush: capture an AND result, then hold stall for 3 cycles with changing inputs → outputs unchanged. Then assert stall+flush together → out_valid=0, ctrl_*_q=0.
- Bubble: in_valid=0 with ctrl_wb=2'b11 → out_valid=0, ctrl_wb_q=0.
- Illegal select: select 101 with in_valid=1 → alu_result 0, illegal_sel=1 and sticky across 5 later legal ops. Select 100 with in_valid=0 → illegal_sel not set.
